// File: rtl/timer_loader_if.sv
// Keypad/timer signal bundle for timer_loader.
// master drives keypad strobes and tick; slave returns the digits.
interface timer_loader_if;
  logic [3:0] bcd;
  logic       loadn;
  logic       startn;
  logic       stopn;
  logic       tick;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;

  modport master (
    output bcd,
    output loadn,
    output startn,
    output stopn,
    output tick,
    input  min_ones,
    input  sec_tens,
    input  sec_ones,
    input  running,
    input  done
  );

  modport slave (
    input  bcd,
    input  loadn,
    input  startn,
    input  stopn,
    input  tick,
    output min_ones,
    output sec_tens,
    output sec_ones,
    output running,
    output done
  );
endinterface

// File: rtl/timer_loader.sv
// Keypad-loaded M:SS countdown timer with IDLE/RUN/DONE control.
// Optional TIMER_LOADER_KEY_SYNC_EN adds a 2-flop input synchronizer.
module timer_loader (
  input  logic           clk,
  input  logic           clearn,
  timer_loader_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [3:0] bcd_i;
  logic       loadn_i;
  logic       startn_i;
  logic       stopn_i;

`ifdef TIMER_LOADER_KEY_SYNC_EN
  logic [3:0] bcd_m, bcd_s;
  logic [2:0] ctl_m, ctl_s;

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      bcd_m <= 4'hF;
      bcd_s <= 4'hF;
      ctl_m <= 3'b111;
      ctl_s <= 3'b111;
    end else begin
      bcd_m <= bus.bcd;
      bcd_s <= bcd_m;
      ctl_m <= {bus.loadn, bus.startn, bus.stopn};
      ctl_s <= ctl_m;
    end
  end

  assign bcd_i    = bcd_s;
  assign loadn_i  = ctl_s[2];
  assign startn_i = ctl_s[1];
  assign stopn_i  = ctl_s[0];
`else
  assign bcd_i    = bus.bcd;
  assign loadn_i  = bus.loadn;
  assign startn_i = bus.startn;
  assign stopn_i  = bus.stopn;
`endif

  logic [1:0] state, state_n;
  logic [3:0] m, t, o;
  logic [3:0] m_n, t_n, o_n;
  logic [3:0] d_m, d_t, d_o;
  logic       load_prev;
  logic       done_q, done_n;
  logic       load_evt;
  logic       shift_ok;
  logic       zero;
  logic       dzero;

  // Falling edge of the sampled strobe; a held-low key fires once.
  assign load_evt = load_prev & ~loadn_i;
  assign shift_ok = load_evt & (bcd_i <= 4'd9);
  assign zero     = ~|{m, t, o};
  assign dzero    = ~|{d_m, d_t, d_o};

  always_comb begin
    d_m = m;
    d_t = t;
    d_o = o;
    if (o != 4'd0) begin
      d_o = o - 4'd1;
    end else begin
      d_o = 4'd9;
      if (t != 4'd0) begin
        d_t = t - 4'd1;
      end else begin
        d_t = 4'd5;
        d_m = m - 4'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    m_n     = m;
    t_n     = t;
    o_n     = o;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!stopn_i) begin
          m_n = 4'd0;
          t_n = 4'd0;
          o_n = 4'd0;
        end else if (!startn_i && !zero) begin
          state_n = RUN;
        end else if (shift_ok) begin
          m_n = t;
          t_n = o;
          o_n = bcd_i;
        end
      end
      RUN: begin
        if (!stopn_i) begin
          state_n = IDLE;
        end else if (bus.tick) begin
          m_n = d_m;
          t_n = d_t;
          o_n = d_o;
          if (dzero) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        if (!stopn_i) begin
          state_n = IDLE;
          m_n     = 4'd0;
          t_n     = 4'd0;
          o_n     = 4'd0;
        end else if (shift_ok) begin
          state_n = IDLE;
          m_n     = t;
          t_n     = o;
          o_n     = bcd_i;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state     <= IDLE;
      m         <= 4'd0;
      t         <= 4'd0;
      o         <= 4'd0;
      load_prev <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      m         <= m_n;
      t         <= t_n;
      o         <= o_n;
      load_prev <= loadn_i;
      done_q    <= done_n;
    end
  end

  assign bus.min_ones = m;
  assign bus.sec_tens = t;
  assign bus.sec_ones = o;
  assign bus.running  = (state == RUN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_timer_loader.sv
// Scenario bench for timer_loader (default build, no input synchronizer).
// Expected values are queued when stimulus is driven, popped on sampling.
module tb_timer_loader;

  logic clk;
  logic clearn;

  timer_loader_if bus ();

  timer_loader dut (
    .clk    (clk),
    .clearn (clearn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [11:0] sb[$];
  logic [11:0] model;
  logic [11:0] exp_v;
  logic [11:0] got_v;

  function automatic logic [11:0] val();
    return {bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  function automatic logic [11:0] to_bcd(input int s);
    logic [3:0] a, b, c;
    a = 4'(s / 60);
    b = 4'((s % 60) / 10);
    c = 4'(s % 10);
    return {a, b, c};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] d);
    bus.bcd   = d;
    bus.loadn = 1'b0;
    cyc();
    bus.loadn = 1'b1;
    bus.bcd   = 4'hF;
    cyc();
  endtask

  task automatic test_reset();
    clearn = 1'b0;
    #2;
    checks++;
    if (val() !== 12'h000) begin
      errors++;
      $display("FAIL reset_digits got=%h exp=000", val());
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL reset_running got=%b exp=0", bus.running);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    cyc();
    clearn = 1'b1;
    cyc();
    model = 12'h000;
  endtask

  task automatic test_load();
    logic [3:0] ds [3];
    ds = '{4'd1, 4'd3, 4'd0};
    for (int i = 0; i < 3; i++) begin
      model = {model[7:0], ds[i]};
      sb.push_back(model);
      load_digit(ds[i]);
      exp_v = sb.pop_front();
      got_v = val();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL load_%0d got=%h exp=%h", i, got_v, exp_v);
      end
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL load_running got=%b exp=0", bus.running);
    end
  endtask

  task automatic test_hold_and_invalid();
    sb.push_back(12'h307);
    bus.bcd   = 4'd7;
    bus.loadn = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    bus.loadn = 1'b1;
    cyc();
    exp_v = sb.pop_front();
    checks++;
    if (val() !== exp_v) begin
      errors++;
      $display("FAIL hold_one_shift got=%h exp=%h", val(), exp_v);
    end
    sb.push_back(12'h307);
    load_digit(4'hF);
    exp_v = sb.pop_front();
    checks++;
    if (val() !== exp_v) begin
      errors++;
      $display("FAIL invalid_bcd got=%h exp=%h", val(), exp_v);
    end
  endtask

  task automatic test_countdown();
    int secs;
    bus.stopn = 1'b0;
    cyc();
    bus.stopn = 1'b1;
    checks++;
    if (val() !== 12'h000) begin
      errors++;
      $display("FAIL idle_clear got=%h exp=000", val());
    end
    load_digit(4'd1);
    load_digit(4'd0);
    load_digit(4'd0);
    checks++;
    if (val() !== 12'h100) begin
      errors++;
      $display("FAIL load_100 got=%h exp=100", val());
    end
    bus.startn = 1'b0;
    cyc();
    bus.startn = 1'b1;
    checks++;
    if (bus.running !== 1'b1) begin
      errors++;
      $display("FAIL start_running got=%b exp=1", bus.running);
    end
    secs = 60;
    for (int i = 0; i < 60; i++) begin
      secs--;
      sb.push_back(to_bcd(secs));
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      exp_v = sb.pop_front();
      checks++;
      if (val() !== exp_v) begin
        errors++;
        $display("FAIL tick_%0d got=%h exp=%h", i, val(), exp_v);
      end
      checks++;
      if (bus.done !== (secs == 0)) begin
        errors++;
        $display("FAIL done_at_%0d got=%b exp=%b", i, bus.done, secs == 0);
      end
      cyc();
      if (i < 59) begin
        checks++;
        if (bus.running !== 1'b1) begin
          errors++;
          $display("FAIL run_at_%0d got=%b exp=1", i, bus.running);
        end
      end
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL done_running got=%b exp=0", bus.running);
    end
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    checks++;
    if (val() !== 12'h000 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got=%h/%b exp=000/0", val(), bus.done);
    end
  endtask

  task automatic test_pause();
    bus.stopn = 1'b0;
    cyc();
    bus.stopn = 1'b1;
    load_digit(4'd0);
    load_digit(4'd0);
    load_digit(4'd5);
    bus.startn = 1'b0;
    cyc();
    bus.startn = 1'b1;
    sb.push_back(12'h005);
    bus.stopn = 1'b0;
    bus.tick  = 1'b1;
    cyc();
    bus.stopn = 1'b1;
    bus.tick  = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (val() !== exp_v) begin
      errors++;
      $display("FAIL pause_hold got=%h exp=%h", val(), exp_v);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL pause_running got=%b exp=0", bus.running);
    end
    bus.stopn = 1'b0;
    cyc();
    bus.stopn = 1'b1;
    checks++;
    if (val() !== 12'h000) begin
      errors++;
      $display("FAIL second_stop got=%h exp=000", val());
    end
  endtask

  task automatic test_zero_start();
    bus.startn = 1'b0;
    cyc();
    bus.startn = 1'b1;
    cyc();
    checks++;
    if (bus.running !== 1'b0) begin
      errors++;
      $display("FAIL zero_start got=%b exp=0", bus.running);
    end
    load_digit(4'd9);
    load_digit(4'd9);
    checks++;
    if (val() !== 12'h099) begin
      errors++;
      $display("FAIL load_099 got=%h exp=099", val());
    end
    bus.startn = 1'b0;
    cyc();
    bus.startn = 1'b1;
    sb.push_back(12'h098);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    exp_v = sb.pop_front();
    checks++;
    if (val() !== exp_v || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL tens9_dec got=%h/%b exp=%h/1", val(), bus.running, exp_v);
    end
    sb.push_back(12'h098);
    load_digit(4'd5);
    exp_v = sb.pop_front();
    checks++;
    if (val() !== exp_v) begin
      errors++;
      $display("FAIL load_in_run got=%h exp=%h", val(), exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.stopn = 1'b0;
    cyc();
    cyc();
    bus.stopn = 1'b1;
    load_digit(4'd4);
    load_digit(4'd2);
    bus.startn = 1'b0;
    cyc();
    bus.startn = 1'b1;
    checks++;
    if (val() !== 12'h042 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort got=%h/%b exp=042/1", val(), bus.running);
    end
    #2;
    clearn = 1'b0;
    #1;
    checks++;
    if (val() !== 12'h000 || bus.running !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_abort got=%h/%b/%b exp=000/0/0",
               val(), bus.running, bus.done);
    end
    cyc();
    clearn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.running !== 1'b0) begin
        errors++;
        $display("FAIL post_abort_%0d got=%b/%b exp=0/0",
                 i, bus.done, bus.running);
      end
    end
  endtask

  initial begin
    clearn     = 1'b0;
    bus.bcd    = 4'hF;
    bus.loadn  = 1'b1;
    bus.startn = 1'b1;
    bus.stopn  = 1'b1;
    bus.tick   = 1'b0;
    model      = 12'h000;
    test_reset();
    test_load();
    test_hold_and_invalid();
    test_countdown();
    test_pause();
    test_zero_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_loader.md
TIMER_LOADER -- requirements
Module: timer_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 clearn  input  1  asynchronous active-low reset.
REQ-004 bcd  input  4  digit from keypad encoder; 0-9 valid, 4'b1111 = no key.
REQ-005 loadn  input  1  active-low digit-valid strobe from the keypad encoder.
REQ-006 startn  input  1  active-low start request, level-sampled.
REQ-007 stopn  input  1  active-low stop/clear request, level-sampled.
REQ-008 tick  input  1  one-cycle 1 Hz enable pulse.
REQ-009 min_ones, sec_tens, sec_ones  output  4 each  BCD timer digits (M:SS).
REQ-010 running  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse on countdown reaching 0:00.

Function
REQ-012 State machine SHALL have states IDLE, RUN and DONE.
REQ-013 A load event SHALL occur on a rising edge where loadn is sampled 0 and was sampled 1 on the previous edge; holding loadn low SHALL yield one event only.
REQ-014 On a load event in IDLE or DONE with bcd <= 9, digits SHALL shift on that same edge: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=bcd; the old min_ones SHALL be discarded; a load event from DONE SHALL also move the state to IDLE.
REQ-015 A load event with bcd > 9 SHALL be ignored; a load event in RUN SHALL be ignored.
REQ-016 IDLE -> RUN when startn = 0 and the digits are not all zero; startn with 0:00 SHALL be ignored.
REQ-017 In RUN, each tick SHALL decrement the value by one second.
REQ-018 Decrement rule: if sec_ones > 0, then sec_ones - 1; else sec_ones = 9, and if sec_tens > 0, then sec_tens - 1; else sec_tens = 5 and min_ones - 1.
REQ-019 Entered sec_tens values 6-9 SHALL be accepted and decremented as plain BCD digits.
REQ-020 When a tick takes the value from 0:01 to 0:00, the state SHALL go to DONE and done SHALL pulse high for exactly that next cycle.
REQ-021 stopn = 0 in RUN SHALL go to IDLE and hold the digits (pause).
REQ-022 stopn = 0 in IDLE or DONE SHALL clear all digits to 0 and go to IDLE.
REQ-023 Priority on the same edge SHALL be stopn > startn > tick > load event.
REQ-024 running SHALL be 1 only in RUN; the digits SHALL hold in DONE.

Reset
REQ-025 clearn = 0 SHALL immediately force IDLE, all digits to 0, running = 0, done = 0, and the loadn history to 1.
REQ-026 Reset asserted mid-RUN SHALL abort the countdown with no done pulse.

Configuration
REQ-027 With TIMER_LOADER_KEY_SYNC_EN defined, bcd, loadn, startn and stopn SHALL pass through a two-flop synchronizer (reset value 1 for the strobes, 4'b1111 for bcd) before use, adding 2 cycles of latency to every input action.
REQ-028 Without TIMER_LOADER_KEY_SYNC_EN, these inputs SHALL be used directly, with the timing given in REQ-013 to REQ-023.

Verification
REQ-029 Reset, then load events with bcd 1, 3, 0 -> digits 1:30, running = 0.
REQ-030 Hold loadn low for 5 cycles with bcd = 7 -> exactly one shift; bcd = 15 with a loadn edge -> no change.
REQ-031 Value 1:00, startn pulse, then one tick -> 0:59; a further 59 ticks -> 0:00, done high for 1 cycle, state DONE.
REQ-032 Value 0:05 in RUN, stopn and tick on the same edge -> IDLE, value stays 0:05; a second stopn -> 0:00.
REQ-033 Value 0:00 with startn = 0 -> stays IDLE, running = 0; entering 9,9 then starting -> 0:99 counts down to 0:98.
REQ-034 clearn pulsed low at 0:42 in RUN -> immediately 0:00, IDLE, no done pulse.
